rx_frame_sequencer: RTL and testbench
=====================================

// Module: rx_frame_sequencer
// PURPOSE
//  Receive-path controller. Sequences demodulator -> decoder -> register field -> host interrupt.
//  Captures two demodulated bytes per frame and starts the decoder on them.
//  Writes the two decoded bytes, then a status byte, through the AMBA-style valid/ready write port.
//  Raises int_rx_host and holds it until the host acknowledges.
// PARAMETERS
//  BASE_ADDR    8'h00  register-field address of decoded byte 0 (byte 1 at BASE_ADDR+1, mod 256)
//  STATUS_ADDR  8'h10  register-field address of the status byte
//  DEC_TIMEOUT  16     max cycles waiting for dec_done after dec_start (range 1..255)
// PORTS
//  G_CLK_RX     in   1  receive clock; all logic rising-edge
//  reset        in   1  asynchronous reset, active-high
//  dem_valid    in   1  one-cycle strobe: dem_data holds a new byte
//  dem_data     in   8  demodulator output byte
//  dec_start    out  1  one-cycle pulse: decoder inputs valid
//  dec_in_0     out  8  captured byte 0 to decoder (BD_DATA_0)
//  dec_in_1     out  8  captured byte 1 to decoder (BD_DATA_1)
//  dec_done     in   1  decoder result valid (sampled only in DEC)
//  dec_out_0    in   8  decoded byte 0
//  dec_out_1    in   8  decoded byte 1
//  dec_err      in   1  decoder error flag; qualified by dec_done
//  bus_valid    out  1  write request to register field
//  bus_address  out  8  write address
//  bus_data     out  8  write data
//  bus_ready    in   1  write accepted when bus_valid & bus_ready
//  int_rx_host  out  1  frame-ready interrupt, level
//  int_ack      in   1  host acknowledge; one cycle suffices
//  frame_count  out  8  frames completed (status write accepted), wraps 255->0
// BEHAVIOUR
//  Reset values (async assert): state IDLE; all outputs 0; captured, decoded and flag registers 0.
//  FSM states: IDLE, CAP1, DEC, WR0, WR1, WRS, IRQ.
//   IDLE: dem_valid -> dec_in_0<=dem_data; go to CAP1.
//   CAP1: dem_valid -> dec_in_1<=dem_data; go to DEC; dec_start=1 in the first DEC cycle only.
//   DEC: timer counts cycles since DEC entry.
//    dec_done -> latch dec_out_0/1 and dec_err; go to WR0.
//    Timer reaches DEC_TIMEOUT with no dec_done -> set to_err; go to WRS (WR0/WR1 skipped).
//    dec_done on the timeout cycle wins (no to_err).
//   WR0: bus_valid=1, bus_address=BASE_ADDR, bus_data=decoded 0.
//   WR1: bus_valid=1, bus_address=BASE_ADDR+1, bus_data=decoded 1.
//   WRS: bus_valid=1, bus_address=STATUS_ADDR,
//        bus_data={to_err,dec_err_l,overrun,1'b0,frame_count[3:0]}.
//        frame_count is its value before the increment.
//   Write handshake (WR0/WR1/WRS): valid, address and data held stable until bus_ready.
//    Acceptance advances the state next cycle.
//    bus_valid deasserts unless the next state also writes; then valid stays high, addr/data change.
//    Back-to-back writes with ready tied high: 1 cycle each.
//   WRS accept: frame_count+1; clear to_err, dec_err_l, overrun; int_rx_host<=1; go to IRQ.
//   IRQ: int_rx_host held high; int_ack -> int_rx_host<=0 next cycle; go to IDLE.
//  Latency: 2nd dem_valid -> dec_start: 1 cycle. dec_done -> first bus_valid: 1 cycle.
//  Overrun: dem_valid in DEC/WR0/WR1/WRS/IRQ drops the byte and sets sticky overrun.
//   Includes dem_valid on the same cycle as int_ack in IRQ.
//  int_ack outside IRQ: ignored. dec_done outside DEC: ignored.
//  Mid-frame reset: immediate return to IDLE; partial frame discarded.
//   Any pending bus write is abandoned (bus_valid=0); frame_count cleared.
// TESTING
//  1. Bytes 8'hA5, 8'h3C; dec_done after 3 cycles with 8'h11/8'h22; bus_ready high ->
//     writes (00,11),(01,22),(10,8'h00); int_rx_host=1; frame_count=1.
//  2. bus_ready low 5 cycles on WR1 -> bus_address=01, bus_data=22 stable all 5 cycles; then one write only.
//  3. No dec_done -> after 16 cycles a single write (10,8'h80) and IRQ; no writes to 00/01.
//  4. dem_valid during WR0 with 8'hFF -> byte dropped; status = 8'h20; next frame starts clean.
//  5. 256 frames -> frame_count wraps to 0; status nibble tracks frame_count[3:0].
//  6. reset pulse while bus_valid high in WR1 -> all outputs 0 asynchronously.
//     Next two bytes form a fresh frame.

Source files
------------

// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - receive-path sequencer: demod capture, decoder launch, register writes, host interrupt
module rx_frame_sequencer #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'h10,
  parameter int         DEC_TIMEOUT = 16
) (
  input  logic       G_CLK_RX,
  input  logic       reset,
  input  logic       dem_valid,
  input  logic [7:0] dem_data,
  output logic       dec_start,
  output logic [7:0] dec_in_0,
  output logic [7:0] dec_in_1,
  input  logic       dec_done,
  input  logic [7:0] dec_out_0,
  input  logic [7:0] dec_out_1,
  input  logic       dec_err,
  output logic       bus_valid,
  output logic [7:0] bus_address,
  output logic [7:0] bus_data,
  input  logic       bus_ready,
  output logic       int_rx_host,
  input  logic       int_ack,
  output logic [7:0] frame_count
);

  typedef enum logic [2:0] {IDLE, CAP1, DEC, WR0, WR1, WRS, IRQ} state_t;

  localparam logic [7:0] BYTE1_ADDR   = BASE_ADDR + 8'd1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(DEC_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] timer;
  logic [7:0] dec1_l;
  logic       to_err, dec_err_l, overrun;
  logic       accept, timeout, drop, ovr_now;

  assign accept  = bus_valid & bus_ready;
  assign timeout = (timer == TIMEOUT_LAST);
  assign drop    = dem_valid & (state inside {DEC, WR0, WR1, WRS, IRQ});
  // A byte dropped in the same cycle the status is built still shows in that status.
  assign ovr_now = overrun | drop;

  function automatic logic [7:0] status_byte(input logic te);
    return {te, dec_err_l, ovr_now, 1'b0, frame_count[3:0]};
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dem_valid) state_next = CAP1;
      CAP1:    if (dem_valid) state_next = DEC;
      DEC: begin
        if (dec_done)     state_next = WR0;
        else if (timeout) state_next = WRS;
      end
      WR0:     if (accept) state_next = WR1;
      WR1:     if (accept) state_next = WRS;
      WRS:     if (accept) state_next = IRQ;
      IRQ:     if (int_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge G_CLK_RX or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 8'd0;
      dec1_l      <= 8'd0;
      to_err      <= 1'b0;
      dec_err_l   <= 1'b0;
      overrun     <= 1'b0;
      dec_start   <= 1'b0;
      dec_in_0    <= 8'd0;
      dec_in_1    <= 8'd0;
      bus_valid   <= 1'b0;
      bus_address <= 8'd0;
      bus_data    <= 8'd0;
      int_rx_host <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state     <= state_next;
      dec_start <= (state == CAP1) && dem_valid;
      case (state)
        IDLE: if (dem_valid) dec_in_0 <= dem_data;
        CAP1: if (dem_valid) begin
          dec_in_1 <= dem_data;
          timer    <= 8'd0;
        end
        DEC: begin
          timer <= timer + 8'd1;
          if (dec_done) begin
            dec1_l      <= dec_out_1;
            dec_err_l   <= dec_err;
            bus_valid   <= 1'b1;
            bus_address <= BASE_ADDR;
            bus_data    <= dec_out_0;
          end else if (timeout) begin
            to_err      <= 1'b1;
            bus_valid   <= 1'b1;
            bus_address <= STATUS_ADDR;
            bus_data    <= status_byte(1'b1);
          end
        end
        WR0: if (accept) begin
          bus_address <= BYTE1_ADDR;
          bus_data    <= dec1_l;
        end
        WR1: if (accept) begin
          bus_address <= STATUS_ADDR;
          bus_data    <= status_byte(to_err);
        end
        WRS: if (accept) begin
          bus_valid   <= 1'b0;
          frame_count <= frame_count + 8'd1;
          to_err      <= 1'b0;
          dec_err_l   <= 1'b0;
          overrun     <= 1'b0;
          int_rx_host <= 1'b1;
        end
        IRQ: if (int_ack) int_rx_host <= 1'b0;
        default: ;
      endcase
      // Placed after the case so a drop in the status-accept cycle survives the clear.
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - directed self-checking bench for rx_frame_sequencer
module tb_rx_frame_sequencer;

  logic       G_CLK_RX = 1'b0;
  logic       reset = 1'b1;
  logic       dem_valid = 1'b0;
  logic [7:0] dem_data = 8'd0;
  logic       dec_start;
  logic [7:0] dec_in_0, dec_in_1;
  logic       dec_done = 1'b0;
  logic [7:0] dec_out_0 = 8'd0, dec_out_1 = 8'd0;
  logic       dec_err = 1'b0;
  logic       bus_valid;
  logic [7:0] bus_address, bus_data;
  logic       bus_ready = 1'b0;
  logic       int_rx_host;
  logic       int_ack = 1'b0;
  logic [7:0] frame_count;

  int passed = 0;
  int total  = 0;

  rx_frame_sequencer dut (
    .G_CLK_RX(G_CLK_RX), .reset(reset),
    .dem_valid(dem_valid), .dem_data(dem_data),
    .dec_start(dec_start), .dec_in_0(dec_in_0), .dec_in_1(dec_in_1),
    .dec_done(dec_done), .dec_out_0(dec_out_0), .dec_out_1(dec_out_1), .dec_err(dec_err),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_data(bus_data), .bus_ready(bus_ready),
    .int_rx_host(int_rx_host), .int_ack(int_ack), .frame_count(frame_count)
  );

  always #5 G_CLK_RX = ~G_CLK_RX;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(negedge G_CLK_RX);
  endtask

  task automatic do_reset();
    reset = 1'b1; dem_valid = 1'b0; dec_done = 1'b0; int_ack = 1'b0; bus_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Ends on the negedge where dec_start is visible (first DEC cycle).
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
    dem_valid = 1'b1; dem_data = b0;
    tick();
    dem_data = b1;
    tick();
    dem_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(bus_valid), 32'd1);
    chk({tag, "_addr"}, 32'(bus_address), 32'(a));
    chk({tag, "_data"}, 32'(bus_data), 32'(d));
  endtask

  // Full frame with ready high and immediate dec_done; returns the status byte and a protocol error count.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] d0,
                           input logic [7:0] d1, output logic [7:0] st, output int bad);
    bad = 0;
    bus_ready = 1'b1;
    send_frame(b0, b1);
    dec_done = 1'b1; dec_out_0 = d0; dec_out_1 = d1;
    tick();
    dec_done = 1'b0;
    if (!(bus_valid && bus_address == 8'h00 && bus_data == d0)) bad++;
    tick();
    if (!(bus_valid && bus_address == 8'h01 && bus_data == d1)) bad++;
    tick();
    if (!(bus_valid && bus_address == 8'h10)) bad++;
    st = bus_data;
    tick();
    if (!int_rx_host || bus_valid) bad++;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    if (int_rx_host) bad++;
  endtask

  initial begin
    logic [7:0] st;
    int bad, hi_cnt, nib_bad;

    tick(); tick();
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_int", 32'(int_rx_host), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_dec_start", 32'(dec_start), 32'd0);
    reset = 1'b0;

    // Scenario 1: basic frame, decoder answers after a few cycles
    bus_ready = 1'b1;
    dem_valid = 1'b1; dem_data = 8'hA5;
    tick();
    chk("t1_dec_in_0", 32'(dec_in_0), 32'hA5);
    dem_data = 8'h3C;
    tick();
    dem_valid = 1'b0;
    chk("t1_dec_start", 32'(dec_start), 32'd1);
    chk("t1_dec_in_1", 32'(dec_in_1), 32'h3C);
    tick();
    chk("t1_dec_start_pulse", 32'(dec_start), 32'd0);
    tick();
    dec_done = 1'b1; dec_out_0 = 8'h11; dec_out_1 = 8'h22;
    tick();
    dec_done = 1'b0;
    check_wr("t1_wr0", 8'h00, 8'h11);
    tick();
    check_wr("t1_wr1", 8'h01, 8'h22);
    tick();
    check_wr("t1_wrs", 8'h10, 8'h00);
    tick();
    chk("t1_int", 32'(int_rx_host), 32'd1);
    chk("t1_bus_idle", 32'(bus_valid), 32'd0);
    chk("t1_frame_count", 32'(frame_count), 32'd1);
    tick(); tick();
    chk("t1_int_held", 32'(int_rx_host), 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t1_int_cleared", 32'(int_rx_host), 32'd0);

    // Scenario 2: bus_ready stalled for 5 cycles on the second data write
    do_reset();
    bus_ready = 1'b1;
    send_frame(8'hA5, 8'h3C);
    dec_done = 1'b1; dec_out_0 = 8'h11; dec_out_1 = 8'h22;
    tick();
    dec_done = 1'b0;
    check_wr("t2_wr0", 8'h00, 8'h11);
    tick();
    bus_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(bus_valid && bus_address == 8'h01 && bus_data == 8'h22)) bad++;
      tick();
    end
    chk("t2_stall_stable", 32'(bad), 32'd0);
    check_wr("t2_wr1_after_stall", 8'h01, 8'h22);
    bus_ready = 1'b1;
    tick();
    check_wr("t2_wrs", 8'h10, 8'h00);
    tick();
    chk("t2_int", 32'(int_rx_host), 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;

    // Scenario 3: decoder never answers -> timeout status only
    do_reset();
    bus_ready = 1'b1;
    send_frame(8'h01, 8'h02);
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus_valid) hi_cnt++;
      tick();
    end
    chk("t3_no_early_write", 32'(hi_cnt), 32'd0);
    check_wr("t3_timeout_status", 8'h10, 8'h80);
    tick();
    chk("t3_int", 32'(int_rx_host), 32'd1);
    chk("t3_frame_count", 32'(frame_count), 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;

    // Scenario 3b: dec_done on the final timeout cycle wins
    do_reset();
    bus_ready = 1'b1;
    send_frame(8'h01, 8'h02);
    for (int i = 0; i < 15; i++) tick();
    dec_done = 1'b1; dec_out_0 = 8'h33; dec_out_1 = 8'h44;
    tick();
    dec_done = 1'b0;
    check_wr("t3b_wr0", 8'h00, 8'h33);
    tick();
    tick();
    check_wr("t3b_status", 8'h10, 8'h00);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;

    // Scenario 4: byte arriving during WR0 is dropped and flagged
    do_reset();
    send_frame(8'hA5, 8'h3C);
    dec_done = 1'b1; dec_out_0 = 8'h55; dec_out_1 = 8'h66;
    tick();
    dec_done = 1'b0;
    dem_valid = 1'b1; dem_data = 8'hFF;
    tick();
    dem_valid = 1'b0;
    chk("t4_dropped", 32'(dec_in_0), 32'hA5);
    check_wr("t4_wr0_held", 8'h00, 8'h55);
    bus_ready = 1'b1;
    tick();
    check_wr("t4_wr1", 8'h01, 8'h66);
    tick();
    check_wr("t4_status_overrun", 8'h10, 8'h20);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    run_frame(8'h12, 8'h34, 8'h77, 8'h88, st, bad);
    chk("t4_next_protocol", 32'(bad), 32'd0);
    chk("t4_next_status_clean", 32'(st), 32'h01);
    chk("t4_next_dec_in_0", 32'(dec_in_0), 32'h12);

    // Scenario 5: 256 frames wrap frame_count; status nibble tracks count
    do_reset();
    nib_bad = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      int b;
      run_frame(8'(i), 8'(i + 1), 8'(i * 3), 8'(i * 5), st, b);
      bad += b;
      if (st !== {4'h0, 4'(i)}) nib_bad++;
    end
    chk("t5_protocol", 32'(bad), 32'd0);
    chk("t5_status_nibble", 32'(nib_bad), 32'd0);
    chk("t5_frame_count_wrap", 32'(frame_count), 32'd0);

    // Scenario 6: asynchronous reset while WR1 is pending
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, st, bad);
    chk("t6_pre_count", 32'(frame_count), 32'd1);
    bus_ready = 1'b1;
    send_frame(8'hA5, 8'h3C);
    dec_done = 1'b1; dec_out_0 = 8'h11; dec_out_1 = 8'h22;
    tick();
    dec_done = 1'b0;
    tick();
    bus_ready = 1'b0;
    check_wr("t6_wr1_pending", 8'h01, 8'h22);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_bus_valid", 32'(bus_valid), 32'd0);
    chk("t6_async_addr_data", 32'({bus_address, bus_data}), 32'd0);
    chk("t6_async_frame_count", 32'(frame_count), 32'd0);
    chk("t6_async_dec_in", 32'({dec_in_0, dec_in_1}), 32'd0);
    chk("t6_async_int", 32'(int_rx_host), 32'd0);
    tick();
    reset = 1'b0;
    run_frame(8'h5A, 8'hC3, 8'h9A, 8'hBC, st, bad);
    chk("t6_fresh_protocol", 32'(bad), 32'd0);
    chk("t6_fresh_status", 32'(st), 32'h00);
    chk("t6_fresh_dec_in", 32'({dec_in_0, dec_in_1}), 32'h5AC3);
    chk("t6_fresh_count", 32'(frame_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
